// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared defaults and the return-tag type for mac_scheduler.
package mac_sched_pkg;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF = 8;
  localparam int ACC_W_DEF = 24;
  localparam int ID_W = 8;
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
    logic last;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; pointer moves past each granted requester.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant,
  output logic [PW-1:0] idx,
  output logic         hit
);
  logic [PW-1:0] ptr;
  always_comb begin
    grant = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (!hit && valid[i] && PW'(i) >= ptr) begin
        hit = 1'b1;
        idx = PW'(i);
      end
    for (int i = 0; i < N; i++)
      if (!hit && valid[i]) begin
        hit = 1'b1;
        idx = PW'(i);
      end
    grant[idx] = hit;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (hit) ptr <= idx == PW'(N - 1) ? '0 : idx + PW'(1);
endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler: shares one pipelined 8x8 multiplier among NREQ dot-product requesters.
// Define MAC_SCHED_SAT_EN to saturate accumulators instead of wrapping.
module mac_scheduler
  import mac_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LAT = LAT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_y,
  output logic [NREQ-1:0]   acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  output logic [NREQ-1:0]   acc_busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 2);
  logic [PW-1:0] gnt_idx;
  logic gnt_hit;
  tag_t tags [LAT+1];
  tag_t ret;
  logic [NREQ-1:0] ret_hit;
  logic [ACC_W-1:0] acc [NREQ];
  logic [CW-1:0] cnt [NREQ];
  logic [ACC_W-1:0] cur, sum;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk(clk),
    .reset(reset),
    .valid(req_valid),
    .grant(req_ready),
    .idx(gnt_idx),
    .hit(gnt_hit)
  );

  assign ret = tags[LAT];

  always_comb begin
    ret_hit = '0;
    cur = '0;
    for (int i = 0; i < NREQ; i++) begin
      ret_hit[i] = ret.valid && ret.id == ID_W'(i);
      cur = ret_hit[i] ? acc[i] : cur;
    end
  end

`ifdef MAC_SCHED_SAT_EN
  logic [ACC_W:0] wide;
  assign wide = {1'b0, cur} + (ACC_W + 1)'(mul_y);
  assign sum = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
`else
  assign sum = cur + ACC_W'(mul_y);
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i <= LAT; i++) tags[i] <= '0;
      for (int i = 0; i < NREQ; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
      mul_a <= '0;
      mul_b <= '0;
      acc_valid <= '0;
      acc_data <= '0;
    end else begin
      tags[0] <= gnt_hit ? tag_t'{valid: 1'b1, id: ID_W'(gnt_idx), last: req_last[gnt_idx]} : '0;
      for (int i = 1; i <= LAT; i++) tags[i] <= tags[i-1];
      mul_a <= gnt_hit ? req_a[8*gnt_idx +: 8] : '0;
      mul_b <= gnt_hit ? req_b[8*gnt_idx +: 8] : '0;
      for (int i = 0; i < NREQ; i++) begin
        if (ret_hit[i]) acc[i] <= ret.last ? '0 : sum;
        cnt[i] <= cnt[i] + CW'(req_ready[i]) - CW'(ret_hit[i]);
      end
      acc_valid <= ret.last ? ret_hit : '0;
      if (ret.last && |ret_hit) acc_data <= sum;
    end

  always_comb
    for (int i = 0; i < NREQ; i++) acc_busy[i] = cnt[i] != '0;
endmodule

// File: doc/mac_scheduler.md
MAC_SCHEDULER -- requirements
Module: mac_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of neuron requesters sharing one multiplier.
REQ-002 SHALL have parameter LAT, default 8, cycles from mul_a/mul_b presented to matching mul_y.
REQ-003 SHALL have parameter ACC_W, default 24, accumulator width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid, req_last  input  NREQ each; per-requester operand valid and last term of dot product.
REQ-007 SHALL have ports req_a, req_b  input  NREQ*8 each; unsigned 8-bit operands, requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  NREQ  one-hot grant.
REQ-009 SHALL have ports mul_a, mul_b  output  8 each; operands to the pipelined 8x8 multiplier.
REQ-010 SHALL have port mul_y  input  16  multiplier product.
REQ-011 SHALL have ports acc_valid  output  NREQ and acc_data  output  ACC_W; one-cycle dot-product result pulse and shared data bus.
REQ-012 SHALL have port acc_busy  output  NREQ  high while requester i has products in flight.

Function
REQ-013 SHALL define a transfer as req_valid[i] & req_ready[i] in one cycle; at most one transfer per cycle.
REQ-014 SHALL drive req_ready combinationally; round-robin starts at pointer p; after grant to i, p becomes (i+1) mod NREQ; p is unchanged if there is no grant.
REQ-015 SHALL register the granted operands onto mul_a/mul_b one cycle after transfer; both 0 in cycles without issue.
REQ-016 SHALL carry a tag {valid, id, last} through an LAT+1 stage shift register aligned so that tag and mul_y coincide.
REQ-017 SHALL zero-extend mul_y to ACC_W and add it to acc[id]; unsigned, wraps modulo 2^ACC_W (see REQ-025).
REQ-018 SHALL, on a returning product with last=1, pulse acc_valid[id] with acc_data = acc[id]+product, and clear acc[id] to 0 in the same update.
REQ-019 SHALL produce total latency of LAT+2 cycles from transfer of the last term to acc_valid.
REQ-020 SHALL hold acc_data at its last value when acc_valid is all-zero; at most one acc_valid bit is high per cycle.
REQ-021 SHALL maintain per-requester in-flight counters (width clog2(LAT+2)): increment on transfer, decrement on return, both in the same cycle leaves the count unchanged; acc_busy[i] = (count != 0).
REQ-022 SHALL allow a requester to issue a new dot product while its previous one is in flight; ordering is preserved by the pipeline.

Reset
REQ-023 SHALL, on reset low at any time, asynchronously clear tags, accumulators, counters, p, mul_a, mul_b, acc_valid, acc_data to 0; in-flight products are discarded and never reported.
REQ-024 SHALL resume normal granting on the first rising clk after reset deasserts.

Configuration
REQ-025 SHALL saturate accumulation at 2^ACC_W-1 when MAC_SCHED_SAT_EN is defined; without the macro it SHALL wrap modulo 2^ACC_W.

Structure
REQ-026 SHALL take NREQ/LAT/ACC_W defaults and the tag typedef from shared package mac_sched_pkg.
REQ-027 SHALL instantiate the round-robin grant logic as sub-module rr_arbiter.

Verification
REQ-028 Single requester: req0 issues (3,4),(5,6,last) -> acc_valid[0] with acc_data=42 exactly LAT+2 cycles after the second transfer.
REQ-029 Contention: all four valid continuously from reset -> grants 0,1,2,3,0,1... one per cycle, and no requester is starved.
REQ-030 Back-to-back dot products: req1 sends (255,255,last),(2,2,last) on consecutive cycles -> acc_data 65025 then 4 on consecutive cycles.
REQ-031 Overflow: ACC_W=16, req2 sends (255,255),(255,255,last) -> 64514 without macro, 65535 with MAC_SCHED_SAT_EN.
REQ-032 Reset mid-flight: reset low 3 cycles after issue -> no acc_valid afterwards, acc_busy=0, the first grant after reset goes to req0.
